// File: rtl/rfm_pkg.sv
// Shared definitions for the multi-bank RFM tracker: scan states, default sizes and the
// saturating-increment rule used by every counter.
package rfm_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StIssue
    } scan_state_e;

    localparam int unsigned NumBankDef      = 4;
    localparam int unsigned BankBitsDef     = 2;
    localparam int unsigned NumEntryDef     = 16;
    localparam int unsigned NumEntryBitsDef = 4;
    localparam int unsigned AddrSizeDef     = 18;
    localparam int unsigned CntSizeDef      = 16;
    localparam int unsigned RfmThDef        = 20;

    // Increment v as a width-bit counter that holds once it reaches all-ones.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
        return (v == max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/rfm_bank_tracker.sv
// One bank's space-saving activation table with spcnt and, when RFM_ALERT_EN is defined,
// the rolling RAA counter that drives rfm_req_o.
module rfm_bank_tracker
    import rfm_pkg::*;
#(
    parameter int unsigned NUM_ENTRY      = NumEntryDef,
    parameter int unsigned NUM_ENTRY_BITS = NumEntryBitsDef,
    parameter int unsigned ADDR_SIZE      = AddrSizeDef,
    parameter int unsigned CNT_SIZE       = CntSizeDef,
    parameter int unsigned RFM_TH         = RfmThDef
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      act_i,
    input  logic [ADDR_SIZE-1:0]      act_addr_i,
    input  logic [NUM_ENTRY_BITS-1:0] rd_idx_i,
    output logic                      rd_valid_o,
    output logic [ADDR_SIZE-1:0]      rd_addr_o,
    output logic [CNT_SIZE-1:0]       rd_cnt_o,
    input  logic                      issue_i,
    input  logic                      issue_wr_i,
    input  logic [NUM_ENTRY_BITS-1:0] issue_idx_i,
    output logic                      rfm_req_o
);

    logic [NUM_ENTRY-1:0] valid_q, valid_d;
    logic [ADDR_SIZE-1:0] addr_q [NUM_ENTRY];
    logic [ADDR_SIZE-1:0] addr_d [NUM_ENTRY];
    logic [CNT_SIZE-1:0]  cnt_q  [NUM_ENTRY];
    logic [CNT_SIZE-1:0]  cnt_d  [NUM_ENTRY];
    logic [CNT_SIZE-1:0]  spcnt_q, spcnt_d;

    logic                      hit, inv, rep;
    logic [NUM_ENTRY_BITS-1:0] hit_idx, inv_idx, rep_idx;
    logic [CNT_SIZE-1:0]       sp_inc;

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_addr_o  = addr_q[rd_idx_i];
    assign rd_cnt_o   = cnt_q[rd_idx_i];

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        spcnt_d = spcnt_q;
        hit     = 1'b0;
        inv     = 1'b0;
        rep     = 1'b0;
        hit_idx = '0;
        inv_idx = '0;
        rep_idx = '0;
        sp_inc  = CNT_SIZE'(sat_inc(32'(spcnt_q), CNT_SIZE));
        // Walk downwards so the lowest matching index is the one left standing.
        for (int i = int'(NUM_ENTRY) - 1; i >= 0; i--) begin
            if (valid_q[i] && addr_q[i] == act_addr_i) begin
                hit     = 1'b1;
                hit_idx = NUM_ENTRY_BITS'(i);
            end
            if (!valid_q[i]) begin
                inv     = 1'b1;
                inv_idx = NUM_ENTRY_BITS'(i);
            end
            if (valid_q[i] && cnt_q[i] == spcnt_q) begin
                rep     = 1'b1;
                rep_idx = NUM_ENTRY_BITS'(i);
            end
        end
        if (act_i) begin
            if (hit) begin
                cnt_d[hit_idx] = CNT_SIZE'(sat_inc(32'(cnt_q[hit_idx]), CNT_SIZE));
            end else if (inv) begin
                valid_d[inv_idx] = 1'b1;
                addr_d[inv_idx]  = act_addr_i;
                cnt_d[inv_idx]   = sp_inc;
            end else if (rep) begin
                addr_d[rep_idx] = act_addr_i;
                cnt_d[rep_idx]  = sp_inc;
            end else begin
                spcnt_d = sp_inc;
            end
        end else if (issue_i && issue_wr_i) begin
            cnt_d[issue_idx_i] = spcnt_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            addr_q  <= '{default: '0};
            cnt_q   <= '{default: '0};
            spcnt_q <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            spcnt_q <= spcnt_d;
        end
    end

`ifdef RFM_ALERT_EN
    logic [CNT_SIZE-1:0] raa_q, raa_d;

    always_comb begin
        raa_d = raa_q;
        if (act_i) begin
            raa_d = CNT_SIZE'(sat_inc(32'(raa_q), CNT_SIZE));
        end else if (issue_i) begin
            raa_d = (raa_q >= CNT_SIZE'(RFM_TH)) ? raa_q - CNT_SIZE'(RFM_TH) : '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            raa_q <= '0;
        end else begin
            raa_q <= raa_d;
        end
    end

    assign rfm_req_o = (raa_q >= CNT_SIZE'(RFM_TH));
`else
    assign rfm_req_o = 1'b0;
`endif

endmodule

// File: rtl/rfm_unit_multibank.sv
// Multi-bank RFM tracker top: command decode, busy/drop logic, the shared hottest-row scan
// engine and the NRR output register. RFM_ALERT_EN enables the per-bank RAA / rfm_req logic.
module rfm_unit_multibank
    import rfm_pkg::*;
#(
    parameter int unsigned NUM_BANK       = NumBankDef,
    parameter int unsigned BANK_BITS      = BankBitsDef,
    parameter int unsigned NUM_ENTRY      = NumEntryDef,
    parameter int unsigned NUM_ENTRY_BITS = NumEntryBitsDef,
    parameter int unsigned ADDR_SIZE      = AddrSizeDef,
    parameter int unsigned CNT_SIZE       = CntSizeDef,
    parameter int unsigned RFM_TH         = RfmThDef
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 act_cmd,
    input  logic [BANK_BITS-1:0] act_bank,
    input  logic [ADDR_SIZE-1:0] act_addr,
    input  logic                 rfm_cmd,
    input  logic [BANK_BITS-1:0] rfm_bank,
    output logic [NUM_BANK-1:0]  bank_busy,
    output logic                 cmd_err,
    output logic [NUM_BANK-1:0]  rfm_req,
    output logic                 nrr_cmd,
    output logic [BANK_BITS-1:0] nrr_bank,
    output logic [ADDR_SIZE-1:0] nrr_addr
);

    scan_state_e state_q, state_d;

    logic                      act_v_q;
    logic [BANK_BITS-1:0]      act_bank_q;
    logic [ADDR_SIZE-1:0]      act_addr_q;
    logic [BANK_BITS-1:0]      scan_bank_q;
    logic [NUM_ENTRY_BITS-1:0] ptr_q;
    logic                      err_q;

    logic                      best_valid_q, best_valid_d;
    logic [NUM_ENTRY_BITS-1:0] best_idx_q, best_idx_d;
    logic [CNT_SIZE-1:0]       best_cnt_q, best_cnt_d;
    logic [ADDR_SIZE-1:0]      best_addr_q, best_addr_d;

    logic                      nrr_cmd_q;
    logic [BANK_BITS-1:0]      nrr_bank_q;
    logic [ADDR_SIZE-1:0]      nrr_addr_q;

    logic [NUM_BANK-1:0]       busy;
    logic                      act_ok, rfm_ok, err_d;
    logic                      last_entry, take, issue_en, nrr_load;

    logic [NUM_BANK-1:0]       rd_valid;
    logic [ADDR_SIZE-1:0]      rd_addr [NUM_BANK];
    logic [CNT_SIZE-1:0]       rd_cnt  [NUM_BANK];

    // A bank is busy while its ACT is being written or while the engine is scanning it.
    always_comb begin
        busy = '0;
        for (int b = 0; b < int'(NUM_BANK); b++) begin
            busy[b] = (act_v_q && act_bank_q == BANK_BITS'(b)) ||
                      (state_q != StIdle && scan_bank_q == BANK_BITS'(b));
        end
    end

    assign act_ok = act_cmd && !busy[act_bank] && !(rfm_cmd && rfm_bank == act_bank);
    assign rfm_ok = rfm_cmd && state_q == StIdle && !busy[rfm_bank];
    assign err_d  = (act_cmd && !act_ok) || (rfm_cmd && !rfm_ok);

    assign last_entry = (ptr_q == NUM_ENTRY_BITS'(NUM_ENTRY - 1));

    // Strictly-greater compare on an ascending scan keeps the lowest index on ties.
    assign take = state_q == StScan && rd_valid[scan_bank_q] &&
                  (!best_valid_q || rd_cnt[scan_bank_q] > best_cnt_q);

    always_comb begin
        best_valid_d = best_valid_q;
        best_idx_d   = best_idx_q;
        best_cnt_d   = best_cnt_q;
        best_addr_d  = best_addr_q;
        if (rfm_ok) begin
            best_valid_d = 1'b0;
        end else if (take) begin
            best_valid_d = 1'b1;
            best_idx_d   = ptr_q;
            best_cnt_d   = rd_cnt[scan_bank_q];
            best_addr_d  = rd_addr[scan_bank_q];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (rfm_ok) state_d = StScan;
            StScan:  if (last_entry) state_d = StIssue;
            StIssue: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        issue_en = (state_q == StIssue);
        nrr_load = (state_q == StScan) && last_entry;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act_v_q      <= 1'b0;
            act_bank_q   <= '0;
            act_addr_q   <= '0;
            scan_bank_q  <= '0;
            ptr_q        <= '0;
            err_q        <= 1'b0;
            best_valid_q <= 1'b0;
            best_idx_q   <= '0;
            best_cnt_q   <= '0;
            best_addr_q  <= '0;
            nrr_cmd_q    <= 1'b0;
            nrr_bank_q   <= '0;
            nrr_addr_q   <= '0;
        end else begin
            act_v_q      <= act_ok;
            err_q        <= err_d;
            best_valid_q <= best_valid_d;
            best_idx_q   <= best_idx_d;
            best_cnt_q   <= best_cnt_d;
            best_addr_q  <= best_addr_d;
            if (act_ok) begin
                act_bank_q <= act_bank;
                act_addr_q <= act_addr;
            end
            if (rfm_ok) begin
                scan_bank_q <= rfm_bank;
                ptr_q       <= '0;
            end else if (state_q == StScan) begin
                ptr_q <= ptr_q + 1'b1;
            end
            // Registered on the last scan cycle so the pulse lands in the ISSUE cycle.
            nrr_cmd_q <= nrr_load && best_valid_d;
            if (nrr_load && best_valid_d) begin
                nrr_bank_q <= scan_bank_q;
                nrr_addr_q <= best_addr_d;
            end
        end
    end

    for (genvar b = 0; b < NUM_BANK; b++) begin : gen_bank
        rfm_bank_tracker #(
            .NUM_ENTRY      (NUM_ENTRY),
            .NUM_ENTRY_BITS (NUM_ENTRY_BITS),
            .ADDR_SIZE      (ADDR_SIZE),
            .CNT_SIZE       (CNT_SIZE),
            .RFM_TH         (RFM_TH)
        ) u_tracker (
            .clk         (clk),
            .rstn        (rstn),
            .act_i       (act_v_q && act_bank_q == BANK_BITS'(b)),
            .act_addr_i  (act_addr_q),
            .rd_idx_i    (ptr_q),
            .rd_valid_o  (rd_valid[b]),
            .rd_addr_o   (rd_addr[b]),
            .rd_cnt_o    (rd_cnt[b]),
            .issue_i     (issue_en && scan_bank_q == BANK_BITS'(b)),
            .issue_wr_i  (best_valid_q),
            .issue_idx_i (best_idx_q),
            .rfm_req_o   (rfm_req[b])
        );
    end

    assign bank_busy = busy;
    assign cmd_err   = err_q;
    assign nrr_cmd   = nrr_cmd_q;
    assign nrr_bank  = nrr_bank_q;
    assign nrr_addr  = nrr_addr_q;

endmodule

// File: tb/tb_rfm_unit_multibank.sv
// Scoreboard bench for rfm_unit_multibank: directed scenarios then random traffic, checked
// against a table-level model of the tracking and scan rules.
module tb_rfm_unit_multibank;

    localparam int NB   = 4;
    localparam int NE   = 16;
    localparam int TH   = 20;
    localparam int SLAT = 17;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        act_cmd = 1'b0;
    logic [1:0]  act_bank = '0;
    logic [17:0] act_addr = '0;
    logic        rfm_cmd = 1'b0;
    logic [1:0]  rfm_bank = '0;
    logic [3:0]  bank_busy;
    logic        cmd_err;
    logic [3:0]  rfm_req;
    logic        nrr_cmd;
    logic [1:0]  nrr_bank;
    logic [17:0] nrr_addr;

    rfm_unit_multibank u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .act_cmd   (act_cmd),
        .act_bank  (act_bank),
        .act_addr  (act_addr),
        .rfm_cmd   (rfm_cmd),
        .rfm_bank  (rfm_bank),
        .bank_busy (bank_busy),
        .cmd_err   (cmd_err),
        .rfm_req   (rfm_req),
        .nrr_cmd   (nrr_cmd),
        .nrr_bank  (nrr_bank),
        .nrr_addr  (nrr_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // Reference model state
    bit m_valid [NB][NE];
    int m_addr  [NB][NE];
    int m_cnt   [NB][NE];
    int m_sp    [NB];
    int m_raa   [NB];
    int busy_until [NB];
    int eng_free;
    bit err_exp [int];
    typedef struct {int cyc; int bank; int addr;} nrr_t;
    nrr_t nq [$];
    bit pend_v   [NB];
    int pend_val [NB];
    int pend_cyc [NB];
    int vis_raa  [NB];
    int last_bank = 0;
    int last_addr = 0;
    nrr_t mon_e;

    function automatic void check(string name, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic int sat(int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    function automatic void model_reset(int c);
        for (int b = 0; b < NB; b++) begin
            for (int e = 0; e < NE; e++) begin
                m_valid[b][e] = 1'b0;
                m_addr[b][e]  = 0;
                m_cnt[b][e]   = 0;
            end
            m_sp[b]       = 0;
            m_raa[b]      = 0;
            busy_until[b] = -1;
            pend_v[b]     = 1'b1;
            pend_val[b]   = 0;
            pend_cyc[b]   = c + 1;
        end
        eng_free = 0;
        err_exp.delete();
        nq.delete();
    endfunction

    function automatic void model_act(int b, int a, int c);
        int hit = -1;
        int inv = -1;
        int rep = -1;
        for (int e = 0; e < NE; e++) begin
            if (hit < 0 && m_valid[b][e] && m_addr[b][e] == a) hit = e;
            if (inv < 0 && !m_valid[b][e]) inv = e;
            if (rep < 0 && m_valid[b][e] && m_cnt[b][e] == m_sp[b]) rep = e;
        end
        if (hit >= 0) begin
            m_cnt[b][hit] = sat(m_cnt[b][hit]);
        end else if (inv >= 0) begin
            m_valid[b][inv] = 1'b1;
            m_addr[b][inv]  = a;
            m_cnt[b][inv]   = sat(m_sp[b]);
        end else if (rep >= 0) begin
            m_addr[b][rep] = a;
            m_cnt[b][rep]  = sat(m_sp[b]);
        end else begin
            m_sp[b] = sat(m_sp[b]);
        end
        m_raa[b]      = sat(m_raa[b]);
        pend_v[b]     = 1'b1;
        pend_val[b]   = m_raa[b];
        pend_cyc[b]   = c + 2;
        busy_until[b] = c + 1;
    endfunction

    function automatic void model_rfm(int b, int c);
        int best = -1;
        nrr_t e;
        for (int i = 0; i < NE; i++) begin
            if (m_valid[b][i] && (best < 0 || m_cnt[b][i] > m_cnt[b][best])) best = i;
        end
        if (best >= 0) begin
            e.cyc  = c + SLAT;
            e.bank = b;
            e.addr = m_addr[b][best];
            nq.push_back(e);
            m_cnt[b][best] = m_sp[b];
        end
        m_raa[b]      = (m_raa[b] >= TH) ? m_raa[b] - TH : 0;
        pend_v[b]     = 1'b1;
        pend_val[b]   = m_raa[b];
        pend_cyc[b]   = c + SLAT + 1;
        busy_until[b] = c + SLAT;
        eng_free      = c + SLAT + 1;
    endfunction

    task automatic step(input bit a, input int ab, input int aa, input bit r, input int rb);
        int  c;
        bit  act_ok, rfm_ok;
        @(negedge clk);
        #2;
        act_cmd  = a;
        act_bank = 2'(ab);
        act_addr = 18'(aa);
        rfm_cmd  = r;
        rfm_bank = 2'(rb);
        c = cyc;
        rfm_ok = r && c >= eng_free && c > busy_until[rb];
        act_ok = a && c > busy_until[ab] && !(r && rb == ab);
        if ((a && !act_ok) || (r && !rfm_ok)) err_exp[c + 1] = 1'b1;
        if (rfm_ok) model_rfm(rb, c);
        if (act_ok) model_act(ab, aa, c);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 0, 1'b0, 0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #2;
        act_cmd = 1'b0;
        rfm_cmd = 1'b0;
        rstn    = 1'b0;
        model_reset(cyc);
        repeat (n) @(negedge clk);
        #2;
        rstn = 1'b1;
    endtask

    // Monitor: runs on the falling edge, before the driver changes anything in that cycle.
    always @(negedge clk) begin
        int exp_busy;
        int exp_req;
        for (int b = 0; b < NB; b++) begin
            if (pend_v[b] && cyc >= pend_cyc[b]) begin
                vis_raa[b] = pend_val[b];
                pend_v[b]  = 1'b0;
            end
        end
        if (!rstn) begin
            last_bank = 0;
            last_addr = 0;
        end
        if (nrr_cmd) begin
            if (nq.size() == 0) begin
                check("nrr_unexpected", int'(nrr_cmd), 0);
            end else begin
                mon_e = nq.pop_front();
                check("nrr_cycle", cyc, mon_e.cyc);
                check("nrr_bank", int'(nrr_bank), mon_e.bank);
                check("nrr_addr", int'(nrr_addr), mon_e.addr);
                last_bank = mon_e.bank;
                last_addr = mon_e.addr;
            end
        end else if (nq.size() > 0 && nq[0].cyc <= cyc) begin
            mon_e = nq.pop_front();
            check("nrr_missing", int'(nrr_cmd), 1);
        end
        check("nrr_bank_hold", int'(nrr_bank), last_bank);
        check("nrr_addr_hold", int'(nrr_addr), last_addr);
        check("cmd_err", int'(cmd_err), err_exp.exists(cyc) ? 1 : 0);
        exp_busy = 0;
        exp_req  = 0;
        for (int b = 0; b < NB; b++) begin
            if (cyc <= busy_until[b]) exp_busy |= (1 << b);
`ifdef RFM_ALERT_EN
            if (vis_raa[b] >= TH) exp_req |= (1 << b);
`endif
        end
        check("bank_busy", int'(bank_busy), exp_busy);
        check("rfm_req", int'(rfm_req), exp_req);
    end

    initial begin
        for (int b = 0; b < NB; b++) vis_raa[b] = 0;
        model_reset(0);
        repeat (3) @(negedge clk);
        #2;
        rstn = 1'b1;

        // Three ACTs to one row, then RFM picks it; a second RFM finds it again at cnt 0.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 0, 'h100, 1'b0, 0);
            idle(1);
        end
        step(1'b0, 0, 0, 1'b1, 0);
        idle(20);
        step(1'b0, 0, 0, 1'b1, 0);
        idle(20);

        // Fill bank 1, overflow into spcnt, then replace entry 0.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1, i, 1'b0, 0);
            idle(1);
        end
        step(1'b1, 1, 'h200, 1'b0, 0);
        idle(1);
        step(1'b1, 1, 'h201, 1'b0, 0);
        idle(1);
        step(1'b0, 0, 0, 1'b1, 1);
        idle(20);

        // RAA threshold on bank 2 and its decrement via RFM.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 2, i % 3, 1'b0, 0);
            idle(1);
        end
        idle(2);
        step(1'b0, 0, 0, 1'b1, 2);
        idle(20);

        // Drops during a scan; another bank still accepts an ACT.
        step(1'b0, 0, 0, 1'b1, 0);
        idle(2);
        step(1'b1, 0, 'h10, 1'b0, 0);
        step(1'b1, 3, 'h20, 1'b0, 0);
        step(1'b0, 0, 0, 1'b1, 1);
        idle(20);

        // Same-cycle ACT and RFM to one bank.
        step(1'b1, 1, 'h55, 1'b1, 1);
        idle(20);

        // Tie between entries 3 and 7 at cnt 5.
        do_reset(2);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3, 'h30 + i, 1'b0, 0);
            idle(1);
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 3, 'h33, 1'b0, 0);
            idle(1);
            step(1'b1, 3, 'h37, 1'b0, 0);
            idle(1);
        end
        step(1'b0, 0, 0, 1'b1, 3);
        idle(20);

        // Reset in the middle of a scan.
        step(1'b0, 0, 0, 1'b1, 3);
        idle(7);
        do_reset(2);
        idle(25);

        // Random traffic over a small row pool so hits, replacements and ties all occur.
        repeat (3000) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, NB - 1)),
                 int'($urandom_range(0, 19)), ($urandom_range(0, 15) == 0),
                 int'($urandom_range(0, NB - 1)));
        end
        idle(40);
        check("scoreboard_drained", nq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
